sr04_ctrl: RTL and testbench

SR04_CTRL -- requirements
Module: sr04_ctrl

---
 rtl/sr04_pkg.sv | 15 +
 rtl/sr04_tick_gen.sv | 38 +++
 rtl/sr04_ctrl.sv | 162 ++++++++++++++++
 tb/tb_sr04_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sr04_pkg.sv
// rtl/sr04_pkg.sv - shared types and constants for the SR04 ranging controller
package sr04_pkg;

   typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} sr04_state_t;

   localparam int US_PER_CM = 58;
   localparam int DIST_W    = 9;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sr04_tick_gen.sv
// rtl/sr04_tick_gen.sv - microsecond and millisecond tick prescalers with synchronous restarts
module sr04_tick_gen #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic us_restart,
   input  logic ms_restart,
   output logic us_tick,
   output logic ms_tick
);

   localparam int US_DIV = CLK_HZ / 1_000_000;
   localparam int MS_DIV = CLK_HZ / 1_000;
   localparam int UW     = $clog2(US_DIV + 1);
   localparam int MW     = $clog2(MS_DIV + 1);
   localparam logic [UW-1:0] US_LAST = UW'(US_DIV - 1);
   localparam logic [MW-1:0] MS_LAST = MW'(MS_DIV - 1);

   logic [UW-1:0] us_cnt;
   logic [MW-1:0] ms_cnt;

   assign us_tick = (us_cnt == US_LAST);
   assign ms_tick = (ms_cnt == MS_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         us_cnt <= '0;
         ms_cnt <= '0;
      end else begin
         if (us_restart || us_tick) us_cnt <= '0;
         else                       us_cnt <= us_cnt + 1'b1;
         if (ms_restart || ms_tick) ms_cnt <= '0;
         else                       ms_cnt <= ms_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sr04_ctrl.sv
// rtl/sr04_ctrl.sv - HC-SR04 ultrasonic ranging controller (trigger, echo timing, cm conversion)
module sr04_ctrl
   import sr04_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int TRIG_US    = 10,
   parameter int RISE_TO_US = 30_000,
   parameter int MAX_CM     = 400,
   parameter int HOLDOFF_US = 60_000,
   parameter int AUTO_MS    = 100
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              auto_en,
   input  logic              echo,
   output logic              trig,
   output logic              busy,
   output logic [DIST_W-1:0] dist_cm,
   output logic              valid,
   output logic              err
);

   localparam int TW = $clog2(max3(TRIG_US, RISE_TO_US, HOLDOFF_US) + 1);
   localparam int AW = $clog2(AUTO_MS + 1);
   localparam int SW = $clog2(US_PER_CM);
   localparam logic [TW-1:0]     TRIG_LAST = TW'(TRIG_US - 1);
   localparam logic [TW-1:0]     RISE_LAST = TW'(RISE_TO_US - 1);
   localparam logic [TW-1:0]     HOLD_LAST = TW'(HOLDOFF_US - 1);
   localparam logic [SW-1:0]     SUB_LAST  = SW'(US_PER_CM - 1);
   localparam logic [DIST_W-1:0] CM_MAX    = DIST_W'(MAX_CM);
   localparam logic [AW-1:0]     AUTO_LAST = AW'(AUTO_MS);
   localparam logic [AW-1:0]     AUTO_PRE  = AW'(AUTO_MS - 1);

   sr04_state_t       state, state_next;
   logic [1:0]        rsync;
   logic              rst_n;
   logic              echo_meta, echo_s, echo_d;
   logic [TW-1:0]     tcnt;
   logic [SW-1:0]     sub;
   logic [DIST_W-1:0] cm;
   logic [DIST_W-1:0] cm_inc;
   logic [AW-1:0]     auto_cnt;
   logic              us_tick, ms_tick, entry, launch, valid_set, err_set;
   logic              rise, fall, sub_wrap, auto_exp;

   // Reset asserts immediately but releases only after two clean clock edges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rsync <= 2'b00;
      else      rsync <= {rsync[0], 1'b1};
   end
   assign rst_n = rsync[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         echo_meta <= 1'b0;
         echo_s    <= 1'b0;
         echo_d    <= 1'b0;
      end else begin
         echo_meta <= echo;
         echo_s    <= echo_meta;
         echo_d    <= echo_s;
      end
   end

   assign rise     = echo_s & ~echo_d;
   assign fall     = ~echo_s & echo_d;
   assign entry    = (state_next != state);
   assign sub_wrap = us_tick && (sub == SUB_LAST);
   assign cm_inc   = cm + 1'b1;
   // Expiry is recognised on the tick itself so launches land exactly AUTO_MS apart.
   assign auto_exp = auto_en && ((auto_cnt == AUTO_LAST) || (ms_tick && auto_cnt == AUTO_PRE));
   assign busy     = (state != IDLE);

   sr04_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
      .clk       (clk),
      .rst_n     (rst_n),
      .us_restart(entry),
      .ms_restart(launch | ~auto_en),
      .us_tick   (us_tick),
      .ms_tick   (ms_tick)
   );

   always_comb begin
      state_next = state;
      launch     = 1'b0;
      valid_set  = 1'b0;
      err_set    = 1'b0;
      case (state)
         IDLE: begin
            if (start || auto_exp) begin
               state_next = TRIG;
               launch     = 1'b1;
            end
         end
         TRIG: begin
            if (us_tick && tcnt == TRIG_LAST) state_next = WAIT_RISE;
         end
         WAIT_RISE: begin
            if (rise) begin
               state_next = MEASURE;
            end else if (us_tick && tcnt == RISE_LAST) begin
               err_set    = 1'b1;
               state_next = HOLDOFF;
            end
         end
         MEASURE: begin
            if (sub_wrap && cm == CM_MAX) begin
               err_set    = 1'b1;
               state_next = HOLDOFF;
            end else if (fall) begin
               valid_set  = 1'b1;
               state_next = HOLDOFF;
            end
         end
         HOLDOFF: begin
            if (us_tick && tcnt == HOLD_LAST) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         trig     <= 1'b0;
         valid    <= 1'b0;
         err      <= 1'b0;
         dist_cm  <= '0;
         tcnt     <= '0;
         sub      <= '0;
         cm       <= '0;
         auto_cnt <= '0;
      end else begin
         state <= state_next;
         trig  <= (state_next == TRIG);
         valid <= valid_set;
         err   <= err_set;
         // A fall coinciding with a wrap reports the incremented count.
         if (valid_set) dist_cm <= sub_wrap ? cm_inc : cm;
         if (entry) begin
            tcnt <= '0;
            sub  <= '0;
            cm   <= '0;
         end else if (us_tick) begin
            if (state == MEASURE) begin
               if (sub_wrap) begin
                  sub <= '0;
                  cm  <= cm_inc;
               end else begin
                  sub <= sub + 1'b1;
               end
            end else if (state != IDLE) begin
               tcnt <= tcnt + 1'b1;
            end
         end
         if (!auto_en || launch)                   auto_cnt <= '0;
         else if (ms_tick && auto_cnt != AUTO_LAST) auto_cnt <= auto_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_sr04_ctrl.sv
// tb/tb_sr04_ctrl.sv - directed self-checking bench for sr04_ctrl
module tb_sr04_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       auto_en = 1'b0;
   logic       echo = 1'b0;
   logic       trig, busy, valid, err;
   logic [8:0] dist_cm;

   int tests = 0;
   int fails = 0;
   int nval, nerr, nrise, ntrig, both, c_val, c_err, c_end, dval, n, n2;
   int rise_c [3];
   logic trig_prev;

   // 2 MHz nominal clock: 2 cycles per us, 2000 cycles per ms.
   sr04_ctrl #(
      .CLK_HZ    (2_000_000),
      .TRIG_US   (10),
      .RISE_TO_US(200),
      .MAX_CM    (30),
      .HOLDOFF_US(300),
      .AUTO_MS   (3)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .auto_en(auto_en),
      .echo   (echo),
      .trig   (trig),
      .busy   (busy),
      .dist_cm(dist_cm),
      .valid  (valid),
      .err    (err)
   );

   always #5 clk = ~clk;

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One start pulse, then an echo of width_c cycles beginning at iteration delay_c.
   task automatic run(input int delay_c, input int width_c, input int poke, input int budget);
      nval = 0; nerr = 0; nrise = 0; ntrig = 0; both = 0;
      c_val = -1; c_err = -1; c_end = -1; dval = -1; trig_prev = 1'b0;
      start = 1'b1;
      step(1);
      start = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (trig) ntrig++;
         if (trig && !trig_prev) nrise++;
         trig_prev = trig;
         if (valid) begin nval++; c_val = c; dval = int'(dist_cm); end
         if (err) begin nerr++; c_err = c; end
         if (valid && err) both++;
         if (!busy) begin c_end = c; break; end
         echo  = (width_c > 0) && (c >= delay_c) && (c < delay_c + width_c);
         start = (poke != 0) && (c == 100 || c == 4000);
         step(1);
      end
      start = 1'b0;
      echo  = 1'b0;
   endtask

   initial begin
      step(3);
      rst = 1'b0;
      step(3);
      chk("rst_trig", trig, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", valid, 0);
      chk("rst_err", err, 0);
      chk("rst_dist", dist_cm, 0);
      rst = 1'b1;
      step(4);

      // 1160 us echo: fall lands on the 20th wrap
      run(69, 2320, 0, 4000);
      chk("m20_trig_cycles", ntrig, 20);
      chk("m20_trig_rises", nrise, 1);
      chk("m20_valid_cnt", nval, 1);
      chk("m20_valid_at", c_val, 2392);
      chk("m20_dist", dval, 20);
      chk("m20_err_cnt", nerr, 0);
      chk("m20_holdoff", c_end - c_val, 600);
      chk("m20_dist_hold", dist_cm, 20);

      run(69, 2318, 0, 4000);
      chk("m19_valid_cnt", nval, 1);
      chk("m19_dist", dval, 19);
      chk("m19_both", both, 0);

      run(0, 0, 0, 2000);
      chk("to_err_at", c_err, 420);
      chk("to_err_cnt", nerr, 1);
      chk("to_valid_cnt", nval, 0);
      chk("to_idle_after", c_end - c_err, 600);
      chk("to_dist_kept", dist_cm, 19);

      run(69, 4000, 1, 6000);
      chk("ov_err_at", c_err, 3668);
      chk("ov_err_cnt", nerr, 1);
      chk("ov_valid_cnt", nval, 0);
      chk("ov_trig_rises", nrise, 1);
      chk("ov_end", c_end, 4268);
      chk("ov_dist_kept", dist_cm, 19);

      // reset in MEASURE
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(69);
      echo = 1'b1;
      step(600);
      chk("rm_busy_before", busy, 1);
      rst = 1'b0;
      #1;
      chk("rm_trig", trig, 0);
      chk("rm_busy", busy, 0);
      chk("rm_dist", dist_cm, 0);
      step(3);
      rst = 1'b1;
      step(100);
      echo = 1'b0;
      n = 0;
      for (int c = 0; c < 800; c++) begin
         if (valid || err || trig || busy) n++;
         step(1);
      end
      chk("rm_quiet_after", n, 0);

      // reset in TRIG
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(5);
      chk("rt_trig_high", trig, 1);
      rst = 1'b0;
      #1;
      chk("rt_trig_drop", trig, 0);
      step(2);
      rst = 1'b1;
      step(4);
      chk("rt_busy_after", busy, 0);

      // periodic mode
      auto_en = 1'b1;
      n = 0;
      trig_prev = trig;
      for (int c = 0; c < 20000 && n < 3; c++) begin
         step(1);
         if (trig && !trig_prev) begin rise_c[n] = c; n++; end
         trig_prev = trig;
      end
      chk("auto_rises", n, 3);
      chk("auto_gap1", rise_c[1] - rise_c[0], 6000);
      chk("auto_gap2", rise_c[2] - rise_c[1], 6000);
      auto_en = 1'b0;
      n2 = 0;
      for (int c = 0; c < 8000; c++) begin
         step(1);
         if (trig && !trig_prev) n2++;
         trig_prev = trig;
      end
      chk("auto_off_rises", n2, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
